// File: rtl/sfot_bus_decoder_pkg.sv
// sfot_bus_pkg: shared FSM states, region select and error data
// for the SFOT CPU bus front end and its address decoder.
package sfot_bus_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ROM_RD  = 3'd1;
  localparam logic [2:0] ST_RAM_RD  = 3'd2;
  localparam logic [2:0] ST_IO_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_e;

  localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/sfot_bus_decoder_if.sv
// sfot_bus_decoder_if: 65C02-side bus cycle handshake.
// master = CPU (req/we/addr/wdata out), slave = decoder.
interface sfot_bus_decoder_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        bus_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rdy, bus_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rdy, bus_err
  );

endinterface

// File: rtl/sfot_bus_decoder_addr_decode.sv
// sfot_addr_decode: combinational region select (ROM > IO > RAM)
// Ports: addr in; region, rom_off, ram_off, io_off out.
module sfot_addr_decode
  import sfot_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE      = 16'hC000,
  parameter int          ROM_ADDR_BITS = 14,
  parameter int          RAM_ADDR_BITS = 15,
  parameter logic [15:0] IO_BASE       = 16'hB000,
  parameter int          IO_ADDR_BITS  = 8
) (
  input  logic [15:0]              addr,
  output region_e                  region,
  output logic [ROM_ADDR_BITS-1:0] rom_off,
  output logic [RAM_ADDR_BITS-1:0] ram_off,
  output logic [IO_ADDR_BITS-1:0]  io_off
);

  localparam logic [ROM_ADDR_BITS-1:0] ROM_LO =
    ROM_BASE[ROM_ADDR_BITS-1:0];
  localparam logic [IO_ADDR_BITS-1:0] IO_LO =
    IO_BASE[IO_ADDR_BITS-1:0];

  logic rom_hit, io_hit, ram_hit;
  logic io_only, ram_only, none;

  assign rom_hit = (addr >> ROM_ADDR_BITS)
                == (ROM_BASE >> ROM_ADDR_BITS);
  assign io_hit  = (addr >> IO_ADDR_BITS)
                == (IO_BASE >> IO_ADDR_BITS);
  assign ram_hit = (addr >> RAM_ADDR_BITS) == 16'd0;

  // Priority folded into exclusive selects
  assign io_only  = io_hit & ~rom_hit;
  assign ram_only = ram_hit & ~rom_hit & ~io_hit;
  assign none     = ~rom_hit & ~io_hit & ~ram_hit;

  assign rom_off = addr[ROM_ADDR_BITS-1:0] - ROM_LO;
  assign io_off  = addr[IO_ADDR_BITS-1:0] - IO_LO;
  assign ram_off = addr[RAM_ADDR_BITS-1:0];

  always_comb begin
    region = REG_NONE;
    unique case (1'b1)
      rom_hit:  region = REG_ROM;
      io_only:  region = REG_IO;
      ram_only: region = REG_RAM;
      none:     region = REG_NONE;
      default:  region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/sfot_bus_decoder.sv
// sfot_bus_decoder: 65C02 bus front end for SFOT boot ROM, RAM, IO.
// Ports: clk, resetn, cpu (slave), ROM/RAM strobes, IO select/ack.
module sfot_bus_decoder
  import sfot_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE      = 16'hC000,
  parameter int          ROM_ADDR_BITS = 14,
  parameter int          RAM_ADDR_BITS = 15,
  parameter logic [15:0] IO_BASE       = 16'hB000,
  parameter int          IO_ADDR_BITS  = 8,
  parameter int          IO_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  sfot_bus_decoder_if.slave        cpu,
  output logic                     rom_enable,
  output logic                     read,
  output logic [15:0]              addra,
  input  logic [7:0]               douta,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata,
  output logic                     io_sel,
  output logic                     io_we,
  output logic [IO_ADDR_BITS-1:0]  io_addr,
  output logic [7:0]               io_wdata,
  input  logic [7:0]               io_rdata,
  input  logic                     io_ack
);

  localparam logic [7:0] TMO = 8'(IO_TIMEOUT);

  region_e                  region;
  logic [ROM_ADDR_BITS-1:0] rom_off;
  logic [RAM_ADDR_BITS-1:0] ram_off;
  logic [IO_ADDR_BITS-1:0]  io_off;

  logic [2:0]               state;
  logic [7:0]               cnt;
  logic [7:0]               rdata_q;
  logic                     err_q;
  logic                     io_we_q;
  logic [IO_ADDR_BITS-1:0]  io_addr_q;
  logic [7:0]               io_wdata_q;
  logic                     accept;

  sfot_addr_decode #(
    .ROM_BASE      (ROM_BASE),
    .ROM_ADDR_BITS (ROM_ADDR_BITS),
    .RAM_ADDR_BITS (RAM_ADDR_BITS),
    .IO_BASE       (IO_BASE),
    .IO_ADDR_BITS  (IO_ADDR_BITS)
  ) u_dec (
    .addr    (cpu.cpu_addr),
    .region  (region),
    .rom_off (rom_off),
    .ram_off (ram_off),
    .io_off  (io_off)
  );

  // Memory strobes fire in the accepting IDLE cycle so the
  // registered ROM/RAM data lands in ROM_RD/RAM_RD.
  assign accept = resetn & (state == ST_IDLE) & cpu.cpu_req;

  assign rom_enable = accept & (region == REG_ROM)
                    & ~cpu.cpu_we;
  assign read       = rom_enable;
  assign addra      = rom_enable
                    ? {{(16-ROM_ADDR_BITS){1'b0}}, rom_off}
                    : 16'd0;

  assign ram_en    = accept & (region == REG_RAM);
  assign ram_we    = ram_en & cpu.cpu_we;
  assign ram_addr  = ram_en ? ram_off : '0;
  assign ram_wdata = ram_we ? cpu.cpu_wdata : 8'd0;

  assign io_sel   = (state == ST_IO_WAIT);
  assign io_we    = io_we_q;
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;

  assign cpu.cpu_rdy   = (state == ST_DONE);
  assign cpu.bus_err   = (state == ST_DONE) & err_q;
  assign cpu.cpu_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      rdata_q    <= 8'd0;
      err_q      <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= 8'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cpu.cpu_req) begin
            err_q <= 1'b0;
            unique case (region)
              REG_ROM: begin
                if (cpu.cpu_we) begin
                  err_q <= 1'b1;
                  state <= ST_DONE;
                end else begin
                  state <= ST_ROM_RD;
                end
              end
              REG_RAM: begin
                state <= cpu.cpu_we ? ST_DONE : ST_RAM_RD;
              end
              REG_IO: begin
                state      <= ST_IO_WAIT;
                cnt        <= 8'd0;
                io_we_q    <= cpu.cpu_we;
                io_addr_q  <= io_off;
                io_wdata_q <= cpu.cpu_we ? cpu.cpu_wdata : 8'd0;
              end
              default: begin
                err_q <= 1'b1;
                if (!cpu.cpu_we) rdata_q <= ERR_DATA;
                state <= ST_DONE;
              end
            endcase
          end
        end
        ST_ROM_RD: begin
          rdata_q <= douta;
          state   <= ST_DONE;
        end
        ST_RAM_RD: begin
          rdata_q <= ram_rdata;
          state   <= ST_DONE;
        end
        ST_IO_WAIT: begin
          // ack beats a coincident timeout
          if (io_ack) begin
            if (!io_we_q) rdata_q <= io_rdata;
            cnt        <= 8'd0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= 8'd0;
            state      <= ST_DONE;
          end else if (cnt == TMO) begin
            rdata_q    <= ERR_DATA;
            err_q      <= 1'b1;
            cnt        <= 8'd0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= 8'd0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfot_bus_decoder.sv
// tb_sfot_bus_decoder: directed vector table plus reset,
// back-to-back and dropped-request sequences.
module tb_sfot_bus_decoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rom_enable, read;
  logic [15:0] addra;
  logic [7:0]  douta = 8'd0;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic        io_sel, io_we;
  logic [7:0]  io_addr, io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;

  int n_cmp = 0;
  int n_bad = 0;

  sfot_bus_decoder_if bus ();

  sfot_bus_decoder dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu        (bus),
    .rom_enable (rom_enable),
    .read       (read),
    .addra      (addra),
    .douta      (douta),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .io_sel     (io_sel),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_ack     (io_ack)
  );

  always #5 clk = ~clk;

  // ROM content: low offset byte xor upper offset bits
  function automatic logic [7:0] rom_byte(input logic [13:0] o);
    return o[7:0] ^ {2'b00, o[13:8]};
  endfunction

  always @(posedge clk)
    if (rom_enable && read) douta <= rom_byte(addra[13:0]);

  logic [7:0] mem [0:32767];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ack_at;
    logic [7:0]  io_data;
    int          lat;
    logic        chk_data;
    logic [7:0]  rdata;
    logic        err;
    int          rom_cnt;
    logic [15:0] addra;
    int          ram_we_cnt;
    logic        is_io;
    logic [7:0]  io_addr;
    logic        io_we;
  } vec_t;

  int          r_lat, r_rom_cnt, r_ram_we_cnt;
  logic [7:0]  r_rdata, r_io_addr;
  logic [15:0] r_addra;
  logic        r_err, r_io_seen, r_io_we;

  task automatic sample_strobes();
    if (rom_enable && read) begin
      r_rom_cnt++;
      r_addra = addra;
    end
    if (ram_we) r_ram_we_cnt++;
  endtask

  // One CPU bus cycle; latency = edge index (req edge = 0)
  // at which cpu_rdy is seen high.
  task automatic do_txn(input logic we,
                        input logic [15:0] addr,
                        input logic [7:0] wd,
                        input int ack_at,
                        input logic [7:0] iod);
    int  io_i;
    bit  done;
    io_i = 0;
    done = 0;
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    r_rom_cnt = 0; r_ram_we_cnt = 0; r_lat = -1;
    r_addra = 16'hDEAD; r_io_seen = 0;
    r_io_addr = 8'h00; r_io_we = 1'b0;
    r_rdata = 8'h00; r_err = 1'b0;
    #1 sample_strobes();
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      io_ack = 1'b0;
      if (bus.cpu_rdy) begin
        r_lat   = k + 1;
        r_rdata = bus.cpu_rdata;
        r_err   = bus.bus_err;
        done    = 1;
        bus.cpu_req = 1'b0;
      end
      sample_strobes();
      if (io_sel) begin
        io_i++;
        if (!r_io_seen) begin
          r_io_seen = 1'b1;
          r_io_addr = io_addr;
          r_io_we   = io_we;
        end
        if (io_i == ack_at) begin
          io_ack   = 1'b1;
          io_rdata = iod;
        end
      end
    end
    bus.cpu_req = 1'b0;
    io_ack = 1'b0;
  endtask

  vec_t vecs[$];
  logic [8:0] mask;
  int rdy_k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
    io_ack = 1'b0; io_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_err", {30'd0, bus.cpu_rdy, bus.bus_err}, 0);
    chk("rst_rdata", {24'd0, bus.cpu_rdata}, 0);
    chk("rst_strobes",
        {24'd0, rom_enable, read, ram_en, ram_we, io_sel,
         io_we, 2'b00}, 0);
    chk("rst_addrs", {addra, io_addr, io_wdata}, 0);
    resetn = 1'b1;

    //           we addr     wd   ack iod  lat d  rdata err
    //           rom addra   rwe  io ioaddr iowe
    vecs.push_back('{0,16'hFFFC,8'h00,0,8'h00,2,1,8'hC3,0,
                     1,16'h3FFC,0,0,8'h00,0});
    vecs.push_back('{1,16'h0200,8'h5A,0,8'h00,1,0,8'h00,0,
                     0,16'h0000,1,0,8'h00,0});
    vecs.push_back('{0,16'h0200,8'h00,0,8'h00,2,1,8'h5A,0,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{1,16'hC000,8'h99,0,8'h00,1,0,8'h00,1,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{0,16'hB010,8'h00,3,8'h42,4,1,8'h42,0,
                     0,16'h0000,0,1,8'h10,0});
    vecs.push_back('{0,16'h9000,8'h00,0,8'h00,1,1,8'hFF,1,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{0,16'hD234,8'h00,0,8'h00,2,1,8'h26,0,
                     1,16'h1234,0,0,8'h00,0});
    vecs.push_back('{0,16'hB020,8'h00,0,8'h00,17,1,8'hFF,1,
                     0,16'h0000,0,1,8'h20,0});
    vecs.push_back('{0,16'hC000,8'h00,0,8'h00,2,1,8'h00,0,
                     1,16'h0000,0,0,8'h00,0});
    vecs.push_back('{0,16'hB0FE,8'h00,16,8'h77,17,1,8'h77,0,
                     0,16'h0000,0,1,8'hFE,0});
    vecs.push_back('{1,16'h7FFF,8'hA7,0,8'h00,1,0,8'h00,0,
                     0,16'h0000,1,0,8'h00,0});
    vecs.push_back('{0,16'h7FFF,8'h00,0,8'h00,2,1,8'hA7,0,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{0,16'h8000,8'h00,0,8'h00,1,1,8'hFF,1,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{0,16'hEA55,8'h00,0,8'h00,2,1,8'h7F,0,
                     1,16'h2A55,0,0,8'h00,0});
    vecs.push_back('{0,16'hB100,8'h00,0,8'h00,1,1,8'hFF,1,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{1,16'hB0FF,8'h33,1,8'h00,2,0,8'h00,0,
                     0,16'h0000,0,1,8'hFF,1});
    vecs.push_back('{1,16'h0000,8'hC4,0,8'h00,1,0,8'h00,0,
                     0,16'h0000,1,0,8'h00,0});
    vecs.push_back('{0,16'h0000,8'h00,0,8'h00,2,1,8'hC4,0,
                     0,16'h0000,0,0,8'h00,0});
    vecs.push_back('{1,16'hAFFF,8'h11,0,8'h00,1,0,8'h00,1,
                     0,16'h0000,0,0,8'h00,0});

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].ack_at, vecs[i].io_data);
      chk($sformatf("v%0d_lat", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'd0, r_err},
          {31'd0, vecs[i].err});
      if (vecs[i].chk_data)
        chk($sformatf("v%0d_rdata", i), {24'd0, r_rdata},
            {24'd0, vecs[i].rdata});
      chk($sformatf("v%0d_rom_cnt", i), r_rom_cnt,
          vecs[i].rom_cnt);
      if (vecs[i].rom_cnt > 0)
        chk($sformatf("v%0d_addra", i), {16'd0, r_addra},
            {16'd0, vecs[i].addra});
      chk($sformatf("v%0d_ram_we", i), r_ram_we_cnt,
          vecs[i].ram_we_cnt);
      chk($sformatf("v%0d_io_sel", i), {31'd0, r_io_seen},
          {31'd0, vecs[i].is_io});
      if (vecs[i].is_io) begin
        chk($sformatf("v%0d_io_addr", i), {24'd0, r_io_addr},
            {24'd0, vecs[i].io_addr});
        chk($sformatf("v%0d_io_we", i), {31'd0, r_io_we},
            {31'd0, vecs[i].io_we});
      end
    end

    // Reset while ROM_RD: transaction aborted, outputs clear
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'hFFFC;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_rdy", {31'd0, bus.cpu_rdy}, 0);
    chk("rstmid_rdata", {24'd0, bus.cpu_rdata}, 0);
    chk("rstmid_strobes",
        {26'd0, rom_enable, read, ram_en, ram_we, io_sel,
         io_we}, 0);
    chk("rstmid_addra", {16'd0, addra}, 0);
    @(posedge clk); #1;
    chk("rstmid_rdy2", {31'd0, bus.cpu_rdy}, 0);
    bus.cpu_req = 1'b0;
    resetn = 1'b1;

    // Back-to-back ROM reads with req held: rdy every 3rd edge
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'hFFFC;
    mask = 9'd0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (bus.cpu_rdy) begin
        mask[k] = 1'b1;
        chk($sformatf("b2b_rdata_k%0d", k),
            {24'd0, bus.cpu_rdata}, 32'h0000_00C3);
      end
    end
    bus.cpu_req = 1'b0;
    chk("b2b_rdy_pattern", {23'd0, mask}, 32'h0000_0092);

    // req dropped after acceptance: still completes
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'hD234;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    rdy_k = -1;
    r_rdata = 8'h00;
    for (int k = 1; k < 6; k++) begin
      if (bus.cpu_rdy && rdy_k < 0) begin
        rdy_k = k;
        r_rdata = bus.cpu_rdata;
      end
      @(posedge clk); #1;
    end
    chk("drop_lat", rdy_k, 2);
    chk("drop_rdata", {24'd0, r_rdata}, 32'h0000_0026);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
